buffered_data_mem: RTL and testbench
====================================

// Module: buffered_data_mem
// PURPOSE
//  Data-memory responder for the five-stage pipeline's M-stage port (A, WD, WE, RD).
//  Stores are posted into an in-order write buffer and retired into a word array that
//  accepts one write every DRAIN_INTERVAL cycles, modelling a slow backing store.
//  Loads see the buffered data immediately. Stall goes to the hazard unit, which holds
//  the M stage while the buffer is full.
// PARAMETERS
//  ADDR_W          6   word-address width; the array holds 2**ADDR_W 32-bit words
//  WB_DEPTH        4   write-buffer entries (power of two, >=2)
//  DRAIN_INTERVAL  2   cycles per array write (>=1; 1 = drain every cycle)
// PORTS
//  clk    in   1          clock; all state updates on the rising edge
//  reset  in   1          asynchronous, active-high; clears all state
//  A      in   32         byte address; word index = A[ADDR_W+1:2], A[1:0] and upper bits ignored
//  WD     in   32         store data
//  WE     in   1          store request for this cycle
//  RD     out  32         load data (combinational)
//  Stall  out  1          store refused this cycle; requester holds A/WD/WE
//  Empty  out  1          write buffer holds no entries
//  Count  out  $clog2(WB_DEPTH)+1   number of valid buffer entries
// BEHAVIOUR
//  Reset (async, high): all buffer entries invalid, head/tail pointers 0, Count 0,
//   drain counter 0, every array word 0. Outputs during/after reset: RD=0, Stall=0, Empty=1.
//   Asserting reset mid-drain discards all pending stores; none reach the array.
//  Read path (0-cycle latency): RD = data of the NEWEST valid buffer entry whose word index
//   matches A; if no entry matches, RD = array[A word index]. RD is valid whether WE is 0 or 1.
//  Store accept: at posedge, if WE=1 and Stall=0, {index, WD} is written at tail, tail+1
//   (mod WB_DEPTH), Count+1. Stall = WE & (Count==WB_DEPTH), combinational. A pop in the
//   same cycle does NOT unblock a full buffer; the store is accepted the next cycle.
//  Drain counter: held at 0 while Count==0. While Count>0 it counts 0..DRAIN_INTERVAL-1.
//   At posedge with Count>0 and counter==DRAIN_INTERVAL-1:
//   - array[head.index] <= head.data
//   - head+1, Count-1, counter <= 0
//  Simultaneous push and pop: Count unchanged, both pointers advance.
//  Drain order is strict FIFO. Repeated stores to one index occupy separate entries;
//   after the drain the array holds the last-stored value. No coalescing.
//  A store accepted at edge N is visible on RD from edge N onward, through the buffer and
//   then the array, with no gap when its entry retires.
//  Pointers wrap modulo WB_DEPTH. Count ranges 0..WB_DEPTH and never over/underflows.
//  Empty = (Count==0).
// TESTING
//  1 Reset: reset=1 mid-run, then read index 0..3 -> RD=0, Empty=1, Count=0, Stall=0.
//  2 Store-to-load forward: WE, A=0x8, WD=0xDEADBEEF, then WE=0, A=0x8 on the next cycle ->
//    RD=0xDEADBEEF with Count=1; with DRAIN_INTERVAL=2, Count=0 two cycles later and
//    RD still 0xDEADBEEF.
//  3 Full/stall: 5 back-to-back stores to A=0x0,0x4,0x8,0xC,0x10 with DRAIN_INTERVAL=4 ->
//    Count reaches 4; on the 5th store Stall=1 until Count<4; when WE is held, the 5th
//    store is accepted exactly once.
//  4 Newest wins: store 0x11 then 0x22 to A=0x20 -> RD=0x22 while both are buffered;
//    array[8]=0x22 after drain, Count=0.
//  5 Wrap/order: 12 stores of data=i to index i, DRAIN_INTERVAL=1 -> pointers wrap 3 times;
//    array[i]=i for i=0..11; Stall is never asserted.
//  6 Reset mid-drain: 3 stores buffered, assert reset for 1 cycle -> array words stay 0,
//    Empty=1; the next store and load behave as in scenario 2.

Source files
------------

// File: rtl/buffered_data_mem.sv
// Data memory for the pipeline M stage. Stores go into an in-order write buffer and
// retire into a slow word array; loads are forwarded from the newest matching entry.
module buffered_data_mem #(
  parameter int ADDR_W         = 6,
  parameter int WB_DEPTH       = 4,
  parameter int DRAIN_INTERVAL = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 A,
  input  logic [31:0]                 WD,
  input  logic                        WE,
  output logic [31:0]                 RD,
  output logic                        Stall,
  output logic                        Empty,
  output logic [$clog2(WB_DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DC_W  = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;
  localparam int WORDS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] buf_idx  [WB_DEPTH];
  logic [31:0]       buf_data [WB_DEPTH];
  logic [31:0]       mem      [WORDS];

  logic [PTR_W-1:0]  head, tail, slot;
  logic [CNT_W-1:0]  count;
  logic [DC_W-1:0]   drain_cnt;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_buf;
  logic              rd_hit, push, pop;
  logic              unused_addr_bits;

  assign rd_idx           = A[ADDR_W+1:2];
  assign unused_addr_bits = ^{A[31:ADDR_W+2], A[1:0]};

  assign Stall = WE && (count == CNT_W'(WB_DEPTH));
  assign push  = WE && !Stall;
  assign pop   = (count != '0) && (drain_cnt == DC_W'(DRAIN_INTERVAL - 1));
  assign Empty = (count == '0);
  assign Count = count;

  // Walk entries oldest to newest so the newest match overrides earlier ones.
  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    rd_hit = 1'b0;
    rd_buf = '0;
    slot   = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (buf_idx[slot] == rd_idx)) begin
        rd_hit = 1'b1;
        rd_buf = buf_data[slot];
      end
    end
  end

  assign RD = rd_hit ? rd_buf : mem[rd_idx];

  // NOTE: buffer payload is not reset; an entry only counts once it lies inside head..head+count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_idx[tail]  <= rd_idx;
      buf_data[tail] <= WD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drain_cnt <= '0;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop) begin
        mem[buf_idx[head]] <= buf_data[head];
        head               <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (count == '0 || pop) drain_cnt <= '0;
      else                    drain_cnt <= drain_cnt + DC_W'(1);
    end
  end

endmodule

// File: tb/tb_buffered_data_mem.sv
// Bench for buffered_data_mem: three instances (drain interval 2, 4, 1) checked every
// cycle against a queue-based model, plus directed scenarios with literal expectations.
module tb_buffered_data_mem;

  localparam int N = 3;
  localparam int DI [N] = '{2, 4, 1};

  typedef struct {
    int          idx;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_s [N];
  logic [31:0] wd_s [N];
  logic        we_s [N];
  logic [31:0] rd_s [N];
  logic        stall_s [N];
  logic        empty_s [N];
  logic [2:0]  count_s [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  buffered_data_mem #(.ADDR_W(6), .WB_DEPTH(4), .DRAIN_INTERVAL(2)) u_di2 (
    .clk(clk), .reset(reset), .A(a_s[0]), .WD(wd_s[0]), .WE(we_s[0]),
    .RD(rd_s[0]), .Stall(stall_s[0]), .Empty(empty_s[0]), .Count(count_s[0]));
  buffered_data_mem #(.ADDR_W(6), .WB_DEPTH(4), .DRAIN_INTERVAL(4)) u_di4 (
    .clk(clk), .reset(reset), .A(a_s[1]), .WD(wd_s[1]), .WE(we_s[1]),
    .RD(rd_s[1]), .Stall(stall_s[1]), .Empty(empty_s[1]), .Count(count_s[1]));
  buffered_data_mem #(.ADDR_W(6), .WB_DEPTH(4), .DRAIN_INTERVAL(1)) u_di1 (
    .clk(clk), .reset(reset), .A(a_s[2]), .WD(wd_s[2]), .WE(we_s[2]),
    .RD(rd_s[2]), .Stall(stall_s[2]), .Empty(empty_s[2]), .Count(count_s[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Model: a queue of pending stores, a word array, and cycles waited by the head entry.
  entry_t      mq [N][$];
  logic [31:0] mmem [N][64];
  int          mwait [N];

  function automatic logic [31:0] model_rd(input int u, input logic [31:0] a);
    int idx = int'(a[7:2]);
    for (int j = mq[u].size() - 1; j >= 0; j--)
      if (mq[u][j].idx == idx) return mq[u][j].data;
    return mmem[u][idx];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int u = 0; u < N; u++) begin
          mq[u].delete();
          mwait[u] = 0;
          for (int w = 0; w < 64; w++) mmem[u][w] = '0;
        end
      end
      for (int u = 0; u < N; u++) begin
        automatic int     sz   = mq[u].size();
        automatic logic   stl  = we_s[u] && (sz == 4);
        automatic logic   drn  = (sz > 0) && (mwait[u] == DI[u] - 1);
        automatic entry_t e;
        check($sformatf("u%0d_rd", u), rd_s[u], model_rd(u, a_s[u]));
        check($sformatf("u%0d_stall", u), stall_s[u], stl);
        check($sformatf("u%0d_empty", u), empty_s[u], sz == 0);
        check($sformatf("u%0d_count", u), count_s[u], sz);
        if (!reset) begin
          if (drn) begin
            e = mq[u].pop_front();
            mmem[u][e.idx] = e.data;
          end
          if (we_s[u] && !stl) begin
            e.idx  = int'(a_s[u][7:2]);
            e.data = wd_s[u];
            mq[u].push_back(e);
          end
          mwait[u] = (sz == 0 || drn) ? 0 : mwait[u] + 1;
        end
      end
    end
  end

  // Inputs change 1 time unit after the edge; outputs are sampled one unit later.
  task automatic cyc(input int u, input logic we, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    we_s[u] = we; a_s[u] = a; wd_s[u] = wd;
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int u = 0; u < N; u++) we_s[u] = 1'b0;
    #1;
    check("reset_empty", empty_s[0], 1'b1);
    check("reset_count", count_s[0], 3'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int stalls;
    int n;
    for (int u = 0; u < N; u++) begin
      a_s[u] = '0; wd_s[u] = '0; we_s[u] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;
    check("init_rd", rd_s[0], 32'h0);
    check("init_empty", empty_s[0], 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Store-to-load forward, then retirement without a gap.
    cyc(0, 1'b1, 32'h8, 32'hDEADBEEF);
    cyc(0, 1'b0, 32'h8, 32'h0);
    check("s2_rd_fwd", rd_s[0], 32'hDEADBEEF);
    check("s2_count1", count_s[0], 3'd1);
    cyc(0, 1'b0, 32'h8, 32'h0);
    cyc(0, 1'b0, 32'h8, 32'h0);
    check("s2_count0", count_s[0], 3'd0);
    check("s2_rd_array", rd_s[0], 32'hDEADBEEF);

    // Reset mid-run wipes both buffer and array.
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 32'(i * 4), 32'h100 + 32'(i));
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1'b0, 32'(i * 4), 32'h0);
      check($sformatf("s1_rd%0d", i), rd_s[0], 32'h0);
    end
    check("s1_rd_old_fwd_word", rd_s[0], 32'h0);
    cyc(0, 1'b0, 32'h8, 32'h0);
    check("s1_rd_word2", rd_s[0], 32'h0);

    // Newest buffered entry wins.
    cyc(0, 1'b1, 32'h20, 32'h11);
    cyc(0, 1'b1, 32'h20, 32'h22);
    cyc(0, 1'b0, 32'h20, 32'h0);
    check("s4_rd_newest", rd_s[0], 32'h22);
    check("s4_count2", count_s[0], 3'd2);
    repeat (6) cyc(0, 1'b0, 32'h20, 32'h0);
    check("s4_rd_array", rd_s[0], 32'h22);
    check("s4_count0", count_s[0], 3'd0);

    // Full buffer stalls; held 5th store is accepted exactly once.
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1'b1, 32'(i * 4), 32'hA0 + 32'(i));
      n = 0;
      while (stall_s[1] && n < 20) begin
        if (n == 0) check("s3_count_full", count_s[1], 3'd4);
        stalls++;
        n++;
        @(posedge clk); #2;
      end
      if (n == 20) check("s3_stall_timeout", stall_s[1], 1'b0);
    end
    check("s3_stall_cycles", stalls, 1);
    cyc(1, 1'b0, 32'h0, 32'h0);
    repeat (24) cyc(1, 1'b0, 32'h0, 32'h0);
    check("s3_count0", count_s[1], 3'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1'b0, 32'(i * 4), 32'h0);
      check($sformatf("s3_rd%0d", i), rd_s[1], 32'hA0 + 32'(i));
    end

    // Drain every cycle: pointers wrap three times, never stalls.
    for (int i = 0; i < 12; i++) begin
      cyc(2, 1'b1, 32'(i * 4), 32'(i));
      check($sformatf("s5_nostall%0d", i), stall_s[2], 1'b0);
    end
    repeat (3) cyc(2, 1'b0, 32'h0, 32'h0);
    check("s5_empty", empty_s[2], 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(2, 1'b0, 32'(i * 4), 32'h0);
      check($sformatf("s5_rd%0d", i), rd_s[2], 32'(i));
    end

    // Reset with stores still pending: none reach the array.
    for (int i = 5; i < 8; i++) cyc(1, 1'b1, 32'(i * 4), 32'h50 + 32'(i));
    pulse_reset();
    for (int i = 5; i < 8; i++) begin
      cyc(1, 1'b0, 32'(i * 4), 32'h0);
      check($sformatf("s6_rd%0d", i), rd_s[1], 32'h0);
      check($sformatf("s6_empty%0d", i), empty_s[1], 1'b1);
    end
    cyc(1, 1'b1, 32'h8, 32'hDEADBEEF);
    cyc(1, 1'b0, 32'h8, 32'h0);
    check("s6_rd_fwd", rd_s[1], 32'hDEADBEEF);
    check("s6_count1", count_s[1], 3'd1);
    repeat (8) cyc(1, 1'b0, 32'h8, 32'h0);
    check("s6_rd_array", rd_s[1], 32'hDEADBEEF);

    @(posedge clk); #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
